// File: rtl/ifetch_prefetch_pkg.sv
// Shared fetch-side definitions: pipeline select/size/opcode constants,
// the prefetch queue entry layout and the word-alignment helper.
package ifetch_prefetch_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [1:0] PCSel_PLUS4  = 2'd0;
    localparam logic [1:0] PCSel_BRANCH = 2'd1;
    localparam logic [1:0] PCSel_JUMP   = 2'd2;
    localparam logic [1:0] PCSel_TRAP   = 2'd3;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Queue entry layout, most significant field first: {pc, instr, halt}.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        halt;
    } IFQ_ENTRY_T;

    function automatic logic is_aligned(input logic [1:0] low_bits);
        return (low_bits & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with flush, used for the prefetch entry queue and the
// in-flight PC queue. Callers rely on credit accounting to avoid overflow.
module ifq_fifo
    import ifetch_prefetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE = AW'(32'd1);
    localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_s, pop_s;

    // Pointer and occupancy update; flush wins over push/pop.
    always_comb begin
        pop_s   = pop_i && (count_q != '0) && !flush_i;
        push_s  = push_i && !flush_i && ((count_q < CW'(DEPTH)) || pop_s);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            if (push_s) begin
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_s) begin
                mem_q[tail_q] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_prefetch.sv
// Decoupled instruction fetch: credit-limited issue to an in-order memory,
// prefetch queue toward decode, redirect flush with stale-response dropping.
module ifetch_prefetch
    import ifetch_prefetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt_in,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc4_out,
    output logic [XLEN-1:0] instr_out,
    output logic            halt_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int EW = 2 * XLEN + 1;
    localparam logic [CW-1:0]   CNT_ONE  = CW'(32'd1);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(32'd4);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic            stopped_q, stopped_d;

    logic [CW-1:0]   q_count_s, pf_count_s;
    logic [EW-1:0]   q_head_s, q_wdata_s;
    logic [XLEN-1:0] pf_head_s;
    logic [SW-1:0]   in_use_s;
    logic            credit_s, aligned_s, issue_s, fire_s, mis_s;
    logic            resp_s, resp_keep_s, q_push_s, q_pop_s, out_valid_s;

    assign in_use_s    = {1'b0, q_count_s} + {1'b0, outstanding_q};
    assign credit_s    = in_use_s < SW'(DEPTH);
    assign aligned_s   = is_aligned(fetch_pc_q[1:0]);
    assign issue_s     = rst && !stopped_q && !halt_in && !redirect && aligned_s && credit_s;
    assign fire_s      = issue_s && imem_req_ready;
    // A misaligned halt entry waits for all older responses so it lands behind them.
    assign mis_s       = !stopped_q && !redirect && !aligned_s && credit_s
                         && (outstanding_q == '0);
    assign resp_s      = imem_resp_valid && (outstanding_q != '0);
    assign resp_keep_s = resp_s && (drop_q == '0) && (pf_count_s != '0);
    assign q_push_s    = !redirect && (resp_keep_s || mis_s);
    assign q_wdata_s   = mis_s ? {fetch_pc_q, {XLEN{1'b0}}, 1'b1}
                               : {pf_head_s, imem_resp_data, 1'b0};
    assign out_valid_s = q_count_s != '0;
    assign q_pop_s     = out_valid_s && out_ready;

    ifq_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_entry_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (q_push_s),
        .wdata_i (q_wdata_s),
        .pop_i   (q_pop_s),
        .rdata_o (q_head_s),
        .count_o (q_count_s)
    );

    ifq_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (fire_s),
        .wdata_i (fetch_pc_q),
        .pop_i   (resp_keep_s),
        .rdata_o (pf_head_s),
        .count_o (pf_count_s)
    );

    // Next-state for fetch address, credit counters and the stop flag.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        stopped_d     = stopped_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (fire_s) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        case ({fire_s, resp_s})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase

        // Every request still unanswered after a redirect edge is stale.
        if (redirect) begin
            drop_d = resp_s ? (outstanding_q - CNT_ONE) : outstanding_q;
        end else if (resp_s && (drop_q != '0)) begin
            drop_d = drop_q - CNT_ONE;
        end else begin
            drop_d = drop_q;
        end

        if (redirect) begin
            stopped_d = 1'b0;
        end else if (mis_s) begin
            stopped_d = 1'b1;
        end else begin
            stopped_d = stopped_q;
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            stopped_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            stopped_q     <= stopped_d;
        end
    end

    assign imem_req_valid = issue_s;
    assign imem_req_addr  = {fetch_pc_q[XLEN-1:2], 2'b00};
    assign out_valid      = out_valid_s;
    assign pc_out         = out_valid_s ? q_head_s[EW-1 -: XLEN] : {XLEN{1'b0}};
    assign pc4_out        = out_valid_s ? (q_head_s[EW-1 -: XLEN] + PC_STEP) : {XLEN{1'b0}};
    assign instr_out      = out_valid_s ? q_head_s[XLEN:1] : {XLEN{1'b0}};
    assign halt_out       = halt_in || (out_valid_s && q_head_s[0]);

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with an in-order fixed-latency memory model.
module tb_ifetch_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt_in = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_ready = 1'b1;
    logic        out_ready = 1'b1;
    logic        imem_req_valid, out_valid, halt_out;
    logic [31:0] imem_req_addr, pc_out, pc4_out, instr_out;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    int vectors = 0;
    int miscompares = 0;
    int lat = 1;

    logic [31:0] m_addr [16];
    int          m_due [16];
    logic [4:0]  m_wr, m_rd;
    int          m_cyc;

    logic [31:0] del_pc[$], del_pc4[$], del_ins[$], req_log[$];

    ifetch_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .halt_in         (halt_in),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .pc_out          (pc_out),
        .pc4_out         (pc4_out),
        .instr_out       (instr_out),
        .halt_out        (halt_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    // Memory: accepted request answered `lat` cycles later, in order.
    assign imem_resp_valid = (m_wr != m_rd) && (m_due[m_rd[3:0]] <= m_cyc);
    assign imem_resp_data  = imem_resp_valid ? instr_of(m_addr[m_rd[3:0]]) : 32'h0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wr  <= 5'd0;
            m_rd  <= 5'd0;
            m_cyc <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (imem_req_valid && imem_req_ready) begin
                m_addr[m_wr[3:0]] <= imem_req_addr;
                m_due[m_wr[3:0]]  <= m_cyc + lat;
                m_wr              <= m_wr + 5'd1;
            end
            if (imem_resp_valid) begin
                m_rd <= m_rd + 5'd1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst && out_valid && out_ready) begin
            del_pc.push_back(pc_out);
            del_pc4.push_back(pc4_out);
            del_ins.push_back(instr_out);
        end
        if (rst && imem_req_valid && imem_req_ready) begin
            req_log.push_back(imem_req_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        del_pc.delete();
        del_pc4.delete();
        del_ins.delete();
        req_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        // Reset values
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_halt_out", 32'(halt_out), 32'd0);
        check("rst_pc_out", pc_out, 32'h0);
        halt_in = 1'b1; #1;
        check("rst_halt_follow", 32'(halt_out), 32'd1);
        halt_in = 1'b0;

        // Streaming with 1-cycle memory
        step(1); rst = 1'b1; #1;
        check("s_req_valid0", 32'(imem_req_valid), 32'd1);
        check("s_req_addr0", imem_req_addr, 32'h0);
        check("s_out_valid_a", 32'(out_valid), 32'd0);
        step(1); #1;
        check("s_out_valid_b", 32'(out_valid), 32'd0);
        check("s_req_addr1", imem_req_addr, 32'h4);
        step(1); #1;
        check("s_out_valid_c", 32'(out_valid), 32'd1);
        check("s_pc0", pc_out, 32'h0);
        check("s_pc4_0", pc4_out, 32'h4);
        check("s_ins0", instr_out, instr_of(32'h0));
        check("s_req_addr2", imem_req_addr, 32'h8);
        step(1); #1;
        check("s_pc1", pc_out, 32'h4);
        check("s_pc4_1", pc4_out, 32'h8);
        step(1); #1;
        check("s_pc2", pc_out, 32'h8);
        check("s_pc4_2", pc4_out, 32'hC);

        // Reset mid-operation, then backpressure
        out_ready = 1'b0; rst = 1'b0; #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        step(1); rst = 1'b1; clear_logs();
        step(5); #1;
        check("bp_req_stall", 32'(imem_req_valid), 32'd0);
        check("bp_head_pc", pc_out, 32'h0);
        step(3); #1;
        check("bp_req_count", 32'(req_log.size()), 32'd4);
        check("bp_req_last", at(req_log, 3), 32'hC);
        out_ready = 1'b1; clear_logs();
        step(6); #1;
        check("bp_drain0", at(del_pc, 0), 32'h0);
        check("bp_drain1", at(del_pc, 1), 32'h4);
        check("bp_drain2", at(del_pc, 2), 32'h8);
        check("bp_drain3", at(del_pc, 3), 32'hC);
        check("bp_resume", at(req_log, 0), 32'h10);

        // Redirect with two requests outstanding, 3-cycle memory
        rst = 1'b0; lat = 3; #1;
        step(1); rst = 1'b1;
        step(2);
        redirect = 1'b1; redirect_pc = 32'h100; clear_logs(); #1;
        check("rd_req_blocked", 32'(imem_req_valid), 32'd0);
        step(1); redirect = 1'b0; #1;
        check("rd_out_valid", 32'(out_valid), 32'd0);
        check("rd_req_valid", 32'(imem_req_valid), 32'd1);
        check("rd_req_addr", imem_req_addr, 32'h100);
        step(8); #1;
        check("rd_first_pc", at(del_pc, 0), 32'h100);
        check("rd_first_ins", at(del_ins, 0), instr_of(32'h100));
        check("rd_second_pc", at(del_pc, 1), 32'h104);

        // Misaligned redirect target
        out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h102; #1;
        step(1); redirect = 1'b0; clear_logs();
        step(8); #1;
        check("mis_out_valid", 32'(out_valid), 32'd1);
        check("mis_pc", pc_out, 32'h102);
        check("mis_pc4", pc4_out, 32'h106);
        check("mis_instr", instr_out, 32'h0);
        check("mis_halt_out", 32'(halt_out), 32'd1);
        check("mis_no_req", 32'(req_log.size()), 32'd0);
        out_ready = 1'b1;
        step(3); #1;
        check("mis_consumed", 32'(out_valid), 32'd0);
        check("mis_halt_clear", 32'(halt_out), 32'd0);
        check("mis_still_stopped", 32'(imem_req_valid), 32'd0);
        check("mis_one_entry", 32'(del_pc.size()), 32'd1);

        // Wrap-around
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        step(1); redirect = 1'b0; clear_logs(); #1;
        check("wr_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
        step(1); #1;
        check("wr_req_addr1", imem_req_addr, 32'h0);
        step(8); #1;
        check("wr_pc", at(del_pc, 0), 32'hFFFF_FFFC);
        check("wr_pc4", at(del_pc4, 0), 32'h0);
        check("wr_ins", at(del_ins, 0), instr_of(32'hFFFF_FFFC));
        check("wr_next_pc", at(del_pc, 1), 32'h0);

        // External halt with two requests outstanding
        rst = 1'b0; #1;
        step(1); rst = 1'b1;
        step(2);
        halt_in = 1'b1; clear_logs(); #1;
        check("h_req_blocked", 32'(imem_req_valid), 32'd0);
        check("h_halt_out", 32'(halt_out), 32'd1);
        step(8); #1;
        check("h_del0", at(del_pc, 0), 32'h0);
        check("h_del1", at(del_pc, 1), 32'h4);
        check("h_del_count", 32'(del_pc.size()), 32'd2);
        check("h_no_req", 32'(req_log.size()), 32'd0);
        check("h_out_valid", 32'(out_valid), 32'd0);
        halt_in = 1'b0; #1;
        check("h_resume_valid", 32'(imem_req_valid), 32'd1);
        check("h_resume_addr", imem_req_addr, 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifetch_prefetch.md
# ifetch_prefetch

Parametrised instruction-fetch front end with a prefetch queue. It replaces the single-register fetch stage with a decoupled engine that keeps up to `DEPTH` requests in flight or buffered against an in-order, variable-latency instruction memory. It delivers instructions to decode over a valid/ready handshake and supports same-cycle redirect for branches and jumps. Misaligned targets and the external halt become a sticky halt indication in program order.

## Interface
- `XLEN`, 32: PC and instruction width.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0: fetch address after reset.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous reset, active-low.
- `halt_in` in 1: stop issuing new fetches while high.
- `redirect` in 1: a branch or jump was taken; flush and refetch.
- `redirect_pc` in XLEN: redirect target.
- `imem_req_valid` out 1: request to instruction memory.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out XLEN: request address, always word-aligned.
- `imem_resp_valid` in 1: in-order response, one per accepted request.
- `imem_resp_data` in XLEN: instruction word.
- `out_valid` out 1: head entry is valid.
- `out_ready` in 1: decode consumes the head entry.
- `pc_out` out XLEN: PC of the head entry.
- `pc4_out` out XLEN: `pc_out + 4`, modulo 2^XLEN.
- `instr_out` out XLEN: instruction of the head entry; 0 for a halt entry.
- `halt_out` out 1: `halt_in` OR the head entry's halt flag.

## Operation
- **State**
  - `fetch_pc`: reset value `RESET_PC`.
  - Queue: pc, instr and halt flag per entry. Head and tail pointers are log2(DEPTH) bits and wrap. `count` is 0..DEPTH.
  - `outstanding`: requests accepted by memory but not yet answered, 0..DEPTH.
  - `drop`: stale responses still to discard, 0..DEPTH.
  - `stopped` flag: reset value 0.
- **Issue**
  - Condition: `!stopped && !halt_in && !redirect && fetch_pc[1:0]==0 && count+outstanding < DEPTH`.
  - While the condition holds, `imem_req_valid=1` and `imem_req_addr=fetch_pc`.
  - On handshake: `fetch_pc += 4` (wraps), `outstanding++`, and the PC is pushed into a small in-flight PC FIFO.
- **Misaligned fetch_pc**
  - No memory request is issued.
  - If `count+outstanding < DEPTH`, enqueue {pc=fetch_pc, instr=0, halt=1} and set `stopped`.
  - Entry ordering places it after all older instructions.
- **Response**
  - If `drop>0`, the response is discarded and `drop--`.
  - Otherwise enqueue {pc from in-flight PC FIFO, `imem_resp_data`, halt=0}.
  - Either way `outstanding--`.
  - Overflow cannot occur because issue is credit-limited.
- **Dequeue**: occurs when `out_valid && out_ready`.
- **Redirect** (highest priority)
  - At the edge: queue emptied, `fetch_pc=redirect_pc`, `stopped=0`, `drop` is set to the number of requests still unanswered, and the in-flight PC FIFO is cleared.
  - A response arriving in the redirect cycle counts against the old `outstanding`, so it is dropped.
  - A dequeue in the redirect cycle is honoured (decode owns that instruction).
- **Halt**
  - `halt_in` only blocks issue. Responses still drain into the queue, and dequeue continues.
  - `halt_out` stays high while a halt entry is at the head. `out_valid` stays 1 until that entry is consumed.

## Timing
- **Reset values**: `out_valid=0`, `imem_req_valid=0` while `rst=0`. `halt_out=halt_in`, with pc/pc4/instr outputs undefined-but-stable (drive 0).
- **First request**: `imem_req_valid` rises combinationally in the first cycle after reset release.
- **Latency**: a response at edge t gives `out_valid=1` in cycle t+1 (registered queue, no bypass).
- **Redirect**
  - Redirect asserted in cycle t: `out_valid=0` in t+1.
  - The first request to `redirect_pc` is issued in t+1.
  - `imem_req_valid=0` in cycle t itself.
- **Simultaneous events**
  - Enqueue and dequeue in the same cycle on a full queue are legal, and `count` is unchanged.
  - Response and issue in the same cycle leave `outstanding` unchanged.
- **Reset mid-operation**: all state clears immediately, and responses to pre-reset requests are the memory's responsibility (memory shares `rst`).
- **Throughput**: one instruction per cycle sustained once `DEPTH` ≥ memory latency + 1.

## Structure
- **Shared package**: holds the `SIZE_*`, `PCSel_*` and opcode constants already used by the pipeline, plus `IFQ_ENTRY_T` (pc, instr, halt) and the `ALIGN_MASK` constant.
- **Sub-module**: one natural sub-module, `ifq_fifo`, a parametrised synchronous FIFO with async active-low reset. It is instantiated twice: the entry queue (width 2·XLEN+1) and the in-flight PC FIFO (width XLEN), both with depth `DEPTH`.

## Test plan
- **Reset and streaming**: `RESET_PC=0`, 1-cycle memory, `out_ready=1` → addresses 0,4,8,… issued back-to-back; `pc_out` sequence 0,4,8 with `pc4_out` 4,8,12; `out_valid` first high 2 cycles after reset release.
- **Backpressure**: `out_ready=0`, DEPTH=4 → exactly 4 requests accepted, then `imem_req_valid=0`; release → 4 entries drained in order and issue resumes at 0x10.
- **Redirect with in-flight requests**: 3-cycle memory, redirect to 0x100 while 2 requests are outstanding → both stale responses dropped; next delivered `pc_out=0x100` with its matching instruction.
- **Misaligned target**: redirect to 0x102 → single entry {pc=0x102, instr=0, halt_out=1}; no memory request for 0x102; further issue blocked until the next redirect.
- **External halt**: `halt_in=1` while 2 requests are outstanding → both responses still delivered, `halt_out=1`, no new requests.
- **Wrap-around**: fetch from 0xFFFFFFFC → `pc4_out=0`; next request address 0x0.
